err_compute: RTL and testbench

Sensor-error producer for the PID path. Sequences eight IR sensor channels through the shared A2D interface with a req/rdy handshake. Accumulates a signed, position-weighted left/right difference and emits one 12-bit signed `error` sample per pass, with a one-cycle valid strobe, to the proportional/integral/derivative term blocks. Detects a stalled A2D with a per-channel timeout.

---
 rtl/err_compute.sv | 130 +++++++++++++
 tb/tb_err_compute.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/err_compute.sv
// rtl/err_compute.sv - position-weighted IR sensor error producer for the PID path
// Optional ERR_FILT_EN adds a 3:1 smoothing filter on the error output.
module err_compute #(
   parameter int TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        strt,
   output logic        a2d_req,
   output logic [2:0]  chnnl,
   input  logic        a2d_rdy,
   input  logic [11:0] a2d_res,
   output logic [11:0] error,
   output logic        err_vld,
   output logic        busy,
   output logic        a2d_flt
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   // Last counter value that still leaves room for a2d_rdy; the flag is then seen TIMEOUT cycles after the request.
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 2);

   state_t             state, state_nxt;
   logic signed [16:0] acc, acc_nxt, sum;
   logic [16:0]        mag;
   logic [1:0]         shift;
   logic [15:0]        cnt, cnt_nxt;
   logic [2:0]         chnnl_nxt;
   logic [11:0]        error_nxt, raw, err_out;
   logic               vld_nxt, flt_nxt, expire;

   // Left channels weigh 8,4,2,1 outward-in; right channels mirror that as 1,2,4,8.
   always_comb begin
      shift = chnnl[2] ? chnnl[1:0] : ~chnnl[1:0];
      mag   = {5'b0, a2d_res} << shift;
      sum   = chnnl[2] ? acc + signed'(mag) : acc - signed'(mag);
      raw   = 12'(sum >>> 5);
   end

`ifdef ERR_FILT_EN
   logic               filt_ok;
   logic signed [13:0] blend;

   always_ff @(posedge clk) begin
      if (rst || expire)
         filt_ok <= 1'b0;
      else if (vld_nxt)
         filt_ok <= 1'b1;
   end

   always_comb begin
      blend   = 14'sd3 * 14'(signed'(error)) + 14'(signed'(raw));
      err_out = filt_ok ? 12'(blend >>> 2) : raw;
   end
`else
   assign err_out = raw;
`endif

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      cnt_nxt   = cnt;
      chnnl_nxt = chnnl;
      error_nxt = error;
      vld_nxt   = 1'b0;
      flt_nxt   = a2d_flt;
      expire    = 1'b0;
      case (state)
         IDLE: begin
            if (strt) begin
               acc_nxt   = '0;
               chnnl_nxt = '0;
               flt_nxt   = 1'b0;
               state_nxt = REQ;
            end
         end
         REQ: begin
            cnt_nxt   = '0;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (a2d_rdy) begin
               acc_nxt = sum;
               if (chnnl == 3'd7) begin
                  error_nxt = err_out;
                  vld_nxt   = 1'b1;
                  state_nxt = DONE;
               end else begin
                  chnnl_nxt = chnnl + 3'd1;
                  state_nxt = REQ;
               end
            end else if (cnt == TO_LAST) begin
               expire    = 1'b1;
               flt_nxt   = 1'b1;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + 16'd1;
            end
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         acc     <= '0;
         cnt     <= '0;
         chnnl   <= '0;
         error   <= '0;
         err_vld <= 1'b0;
         a2d_req <= 1'b0;
         busy    <= 1'b0;
         a2d_flt <= 1'b0;
      end else begin
         state   <= state_nxt;
         acc     <= acc_nxt;
         cnt     <= cnt_nxt;
         chnnl   <= chnnl_nxt;
         error   <= error_nxt;
         err_vld <= vld_nxt;
         a2d_req <= (state_nxt == REQ);
         busy    <= (state_nxt != IDLE);
         a2d_flt <= flt_nxt;
      end
   end

endmodule

// File: tb/tb_err_compute.sv
// tb/tb_err_compute.sv - randomized scoreboard bench for err_compute
module tb_err_compute;
   localparam int TO = 20;

   logic        clk = 1'b0;
   logic        rst, strt, a2d_req, a2d_rdy, err_vld, busy, a2d_flt;
   logic [2:0]  chnnl;
   logic [11:0] a2d_res, error;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int chan_val[8];
   int delay[8];
   int weight[8] = '{-8, -4, -2, -1, 1, 2, 4, 8};
   int stall_ch = -1;
   bit spurious = 1'b0;
   int exp_q[$];
   int cyc_q[$];
   int last_err = 0;
   bit filt_first = 1'b1;

   err_compute #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .strt(strt), .a2d_req(a2d_req), .chnnl(chnnl),
      .a2d_rdy(a2d_rdy), .a2d_res(a2d_res), .error(error), .err_vld(err_vld),
      .busy(busy), .a2d_flt(a2d_flt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int got, input int want);
      tests++;
      if (got != want) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endtask

   function automatic int floor_div(input int n, input int d);
      return (n >= 0) ? n / d : -((-n + d - 1) / d);
   endfunction

   function automatic int model_raw();
      int s = 0;
      for (int i = 0; i < 8; i++) s += weight[i] * chan_val[i];
      return floor_div(s, 32);
   endfunction

   // A2D model: answers each request after delay[ch] cycles, or never for the stalled channel.
   initial begin
      int ch;
      a2d_rdy = 1'b0;
      a2d_res = '0;
      forever begin
         @(negedge clk);
         a2d_rdy = 1'b0;
         if (a2d_req && !rst && int'(chnnl) != stall_ch) begin
            ch = int'(chnnl);
            if (spurious) begin
               a2d_rdy = 1'b1;
               a2d_res = 12'hFFF;
            end
            repeat (delay[ch] - 1) @(negedge clk);
            @(negedge clk);
            a2d_rdy = 1'b1;
            a2d_res = 12'(chan_val[ch]);
         end
      end
   end

   // Scoreboard monitor
   always @(negedge clk) begin
      if (err_vld) begin
         if (exp_q.size() == 0) begin
            check("unexpected_err_vld", 1, 0);
         end else begin
            check("error", int'($signed(error)), exp_q.pop_front());
            check("err_vld_cycle", cyc, cyc_q.pop_front());
         end
      end
   end

   task automatic run_pass(input bit expect_done, input int poke_off);
      int raw, want, t0, tcyc, pk;
      t0   = cyc;
      tcyc = t0 + 1;
      for (int i = 0; i < 8; i++) tcyc += 1 + delay[i];
      pk = (poke_off > 0) ? t0 + poke_off : -1;
      if (expect_done) begin
         raw = model_raw();
`ifdef ERR_FILT_EN
         want = filt_first ? raw : floor_div(3 * last_err + raw, 4);
`else
         want = raw;
`endif
         filt_first = 1'b0;
         last_err   = want;
         exp_q.push_back(want);
         cyc_q.push_back(tcyc);
      end
      strt = 1'b1;
      @(negedge clk);
      strt = 1'b0;
      check("req_after_strt", int'(a2d_req), 1);
      check("busy_after_strt", int'(busy), 1);
      check("chnnl_start", int'(chnnl), 0);
      check("flt_cleared", int'(a2d_flt), 0);
      if (expect_done) begin
         for (int k = 0; k < 3000 && busy; k++) begin
            strt = (cyc == pk);
            @(negedge clk);
         end
         strt = 1'b0;
         check("busy_fall_cycle", cyc, tcyc + 1);
         @(negedge clk);
         check("stays_idle", int'(busy), 0);
      end
   endtask

   task automatic set_vals(input int lo, input int hi);
      for (int i = 0; i < 8; i++) begin
         chan_val[i] = (i < 4) ? lo : hi;
         delay[i]    = 1;
      end
   endtask

   initial begin
      int t0;
      rst  = 1'b1;
      strt = 1'b0;
      set_vals(0, 0);
      repeat (3) @(negedge clk);
      check("rst_req", int'(a2d_req), 0);
      check("rst_chnnl", int'(chnnl), 0);
      check("rst_error", int'(error), 0);
      check("rst_vld", int'(err_vld), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_flt", int'(a2d_flt), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      set_vals(0, 0);
      chan_val[7] = 4095;
      run_pass(1'b1, 0);
`ifndef ERR_FILT_EN
      check("dir_ch7", int'($signed(error)), 1023);
`endif

      stall_ch = 3;
      t0 = cyc;
      run_pass(1'b0, 0);
      for (int k = 0; k < TO + 50 && !a2d_flt; k++) @(negedge clk);
      check("flt_raised", int'(a2d_flt), 1);
      check("flt_cycle", cyc, t0 + 7 + TO);
      check("flt_busy", int'(busy), 0);
      check("flt_error_held", int'($signed(error)), last_err);
      check("flt_chnnl", int'(chnnl), 3);
      filt_first = 1'b1;
      stall_ch = -1;
      repeat (2) @(negedge clk);

      set_vals(0, 0);
      chan_val[0] = 4095;
      run_pass(1'b1, 0);
`ifndef ERR_FILT_EN
      check("dir_ch0", int'($signed(error)), -1024);
`endif
      set_vals(0, 4095);
      run_pass(1'b1, 0);
`ifndef ERR_FILT_EN
      check("dir_right_max", int'($signed(error)), 1919);
`endif
      set_vals(2000, 2000);
      run_pass(1'b1, 6);
`ifndef ERR_FILT_EN
      check("dir_balance", int'($signed(error)), 0);
`endif

      set_vals(0, 0);
      for (int i = 0; i < 8; i++) chan_val[i] = $urandom_range(0, 4094);
      spurious = 1'b1;
      run_pass(1'b1, 0);
      spurious = 1'b0;
      run_pass(1'b1, 17);

      set_vals(300, 900);
      delay[5] = 6;
      run_pass(1'b0, 0);
      for (int k = 0; k < 200 && !(a2d_req && chnnl == 3'd5); k++) @(negedge clk);
      check("reach_ch5", int'(chnnl), 5);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_req", int'(a2d_req), 0);
      check("midrst_chnnl", int'(chnnl), 0);
      check("midrst_error", int'(error), 0);
      check("midrst_vld", int'(err_vld), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_flt", int'(a2d_flt), 0);
      filt_first = 1'b1;
      last_err = 0;
      repeat (10) @(negedge clk);

      set_vals(0, 0);
      chan_val[7] = 4000;
      run_pass(1'b1, 0);
      set_vals(0, 0);
      run_pass(1'b1, 0);
`ifdef ERR_FILT_EN
      check("filt_second", int'($signed(error)), 750);
`else
      check("unfilt_zero", int'($signed(error)), 0);
`endif

      for (int p = 0; p < 12; p++) begin
         for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 3))
               0: chan_val[i] = 0;
               1: chan_val[i] = 4095;
               default: chan_val[i] = $urandom_range(0, 4095);
            endcase
            delay[i] = $urandom_range(1, 4);
         end
         run_pass(1'b1, 0);
      end

      repeat (3) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
      $fatal(1);
   end

endmodule
